// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the unified-memory port arbiter of the multi-cycle
// RV32I core: FSM state encoding, requester IDs, default widths and the NOP
// instruction word.
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // Requester IDs; also the encoding of the last-winner register
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arb_select.sv
// ---------------------------------------------------------------------------
// mem_arb_select
// Chooses the winner between fetch and data requests and keeps the
// priority history.
//   Default build      : data wins conflicts; fetch is forced to win once it
//                        has lost MAX_WAIT consecutive conflicts.
//   ROUND_ROBIN_EN     : on a conflict the loser of the previous conflict
//                        wins; non-conflict grants leave the history alone.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   if_req      fetch request
//   d_req       data request
//   gnt_en      a grant is issued this cycle (history update strobe)
//   win_d       1 = data wins, 0 = fetch wins (only meaningful with a request)
// ---------------------------------------------------------------------------
module mem_arb_select
   import riscv_mem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic d_req,
   input  logic gnt_en,
   output logic win_d
);

   logic conflict;
   assign conflict = if_req & d_req;

`ifdef ROUND_ROBIN_EN
   logic last_q, last_d;

   always_comb begin
      last_d = last_q;
      win_d  = d_req;
      if (conflict) begin
         win_d = (last_q == REQ_IF);
      end
      if (gnt_en && conflict) begin
         last_d = win_d ? REQ_D : REQ_IF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= REQ_IF;
      else        last_q <= last_d;
   end
`else
   logic [3:0] wait_q, wait_d;

   always_comb begin
      wait_d = wait_q;
      win_d  = d_req;
      if (conflict) begin
         win_d = (wait_q != 4'(MAX_WAIT));
      end
      // Counter only moves when a grant is actually issued: a fetch loss
      // bumps it, anything else (fetch win or fetch idle) clears it.
      if (gnt_en) begin
         wait_d = (win_d && if_req) ? wait_q + 4'd1 : 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_q <= 4'd0;
      else        wait_q <= wait_d;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port unified I/D memory between instruction fetch and
// data load/store. A request is granted combinationally in IDLE, the memory
// is driven for exactly one cycle (ACCESS) and the registered response is
// returned with a one-cycle rvalid pulse (RESP).
// Optional macro ROUND_ROBIN_EN selects round-robin conflict resolution
// instead of fixed data priority with the MAX_WAIT starvation guard.
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   if_req/if_addr -> if_gnt           fetch request / accept
//   if_rvalid/if_rdata                 fetch response
//   d_req/d_we/d_addr/d_wdata -> d_gnt data request / accept
//   d_rvalid/d_rdata/d_err             data response (err = misaligned)
//   mem_we/mem_addr/mem_wdata/mem_rdata  memory port (comb read, sync write)
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic              we_q,    we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q,   err_d;

   logic gnt_en, win_d, in_access, in_resp, aligned, d_misalign;

   assign gnt_en     = (state_q == IDLE) && (if_req || d_req);
   assign in_access  = (state_q == ACCESS);
   assign in_resp    = (state_q == RESP);
   assign aligned    = (addr_q[1:0] == 2'b00);
   // Fetch ignores the low address bits; only data can be misaligned
   assign d_misalign = (owner_q == REQ_D) && !aligned;

   mem_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
      .clk    (clk),
      .rst_n  (rst_n),
      .if_req (if_req),
      .d_req  (d_req),
      .gnt_en (gnt_en),
      .win_d  (win_d)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (gnt_en) begin
               owner_d = win_d ? REQ_D : REQ_IF;
               addr_d  = win_d ? d_addr : if_addr;
               we_d    = win_d & d_we;
               wdata_d = win_d ? d_wdata : '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            err_d = d_misalign;
            // Stores and misaligned data accesses return zero data
            rdata_d = (we_q || d_misalign) ? '0 : mem_rdata;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= REQ_IF;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign if_gnt = gnt_en & ~win_d;
   assign d_gnt  = gnt_en &  win_d;

   // Memory port decoded from state so reset drops mem_we immediately
   assign mem_we    = in_access & we_q & aligned;
   assign mem_addr  = in_access ? addr_q  : '0;
   assign mem_wdata = in_access ? wdata_q : '0;

   assign if_rvalid = in_resp && (owner_q == REQ_IF);
   assign d_rvalid  = in_resp && (owner_q == REQ_D);
   assign if_rdata  = if_rvalid ? rdata_q : '0;
   assign d_rdata   = d_rvalid  ? rdata_q : '0;
   assign d_err     = d_rvalid & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a 32-word behavioural memory.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Unified memory: combinational read, synchronous write
   logic [31:0] mem [32];
   assign mem_rdata = mem[mem_addr[6:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference arbitration model ----------------
   int   m_loss = 0;      // consecutive conflicts fetch has lost
   logic m_last_d = 0;    // data won the previous conflict

   function automatic logic model_grant(input logic fi, input logic fd);
      logic wd;
`ifdef ROUND_ROBIN_EN
      wd = fd;
      if (fi && fd) begin
         wd = !m_last_d;
         m_last_d = wd;
      end
`else
      if (fi && fd) wd = (m_loss != MAX_WAIT);
      else          wd = fd;
      m_loss = (wd && fi) ? m_loss + 1 : 0;
`endif
      return wd;
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        ir, dr, dwe;
      logic [31:0] ia, da, dwd;
      logic        eig, edg, ewe, eerr;
      logic [31:0] erd;
   } vec_t;
   vec_t tbl[7];

   typedef struct {
      int          due;
      logic        is_d;
      logic        err;
      logic [31:0] data;
   } rsp_t;
   rsp_t q[$];

   logic [31:0] mmem [32];

   initial begin
      logic        exp_d, owner_d;
      int          n;
      logic        if_pend, d_pend, d_w;
      logic [31:0] if_a, d_a, d_wd;
      int          next_free, we_cyc;
      logic [31:0] we_addr, we_data;
      rsp_t        r;

      for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
      mem[0] = 32'h0011_2223;
      mem[1] = 32'h0041_2683;

      //         ir  dr  dwe ia     da     dwd            eig edg ewe err erd
      tbl[0] = '{1'b1,1'b0,1'b0,32'h0,32'h0,32'h0,         1'b1,1'b0,1'b0,1'b0,32'h0011_2223};
      tbl[1] = '{1'b0,1'b1,1'b1,32'h0,32'h8,32'hDEAD_BEEF, 1'b0,1'b1,1'b1,1'b0,32'h0};
      tbl[2] = '{1'b0,1'b1,1'b0,32'h0,32'h8,32'h0,         1'b0,1'b1,1'b0,1'b0,32'hDEAD_BEEF};
      tbl[3] = '{1'b0,1'b1,1'b1,32'h0,32'h6,32'h5555_5555, 1'b0,1'b1,1'b0,1'b1,32'h0};
      tbl[4] = '{1'b0,1'b1,1'b0,32'h0,32'h4,32'h0,         1'b0,1'b1,1'b0,1'b0,32'h0041_2683};
      tbl[5] = '{1'b1,1'b0,1'b0,32'h5,32'h0,32'h0,         1'b1,1'b0,1'b0,1'b0,32'h0041_2683};
      tbl[6] = '{1'b0,1'b1,1'b0,32'h0,32'h9,32'h0,         1'b0,1'b1,1'b0,1'b1,32'h0};

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk("rst_if_gnt", if_gnt, 0);       chk("rst_d_gnt", d_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);   chk("rst_d_rdata", d_rdata, 0);
      chk("rst_d_err", d_err, 0);         chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;

      // ---- table: single transactions from IDLE ----
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         if_req = tbl[i].ir; if_addr = tbl[i].ia;
         d_req = tbl[i].dr; d_we = tbl[i].dwe; d_addr = tbl[i].da; d_wdata = tbl[i].dwd;
         @(negedge clk);
         chk($sformatf("v%0d_if_gnt", i), if_gnt, tbl[i].eig);
         chk($sformatf("v%0d_d_gnt", i), d_gnt, tbl[i].edg);
         @(posedge clk); #1;
         // garbage after grant must not disturb the latched transaction
         if_req = 0; d_req = 0; d_we = ~d_we; d_addr = 32'h7C; d_wdata = 32'hFFFF_FFFF; if_addr = 32'h7C;
         @(negedge clk);
         chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].ewe);
         chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].ir ? tbl[i].ia : tbl[i].da);
         if (tbl[i].ewe) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].dwd);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_if_rvalid", i), if_rvalid, tbl[i].eig);
         chk($sformatf("v%0d_d_rvalid", i), d_rvalid, tbl[i].edg);
         chk($sformatf("v%0d_rdata", i), tbl[i].eig ? if_rdata : d_rdata, tbl[i].erd);
         chk($sformatf("v%0d_d_err", i), d_err, tbl[i].eerr);
         chk($sformatf("v%0d_mem_we_off", i), mem_we, 0);
         d_we = 0;
      end
      chk("mis_store_word1", mem[1], 32'h0041_2683);
      chk("store_word2", mem[2], 32'hDEAD_BEEF);

      // ---- continuous conflict ----
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h8;
      n = 0; owner_d = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         @(negedge clk);
         if (if_rvalid || d_rvalid) begin
            chk("conf_rvalid_owner", d_rvalid, owner_d);
            chk("conf_rvalid_single", if_rvalid & d_rvalid, 0);
            if (if_rvalid) chk("conf_if_rdata", if_rdata, 32'h0041_2683);
            if (d_rvalid)  chk("conf_d_rdata", d_rdata, 32'hDEAD_BEEF);
         end
         if (if_gnt || d_gnt) begin
            exp_d = model_grant(1'b1, 1'b1);
            chk($sformatf("conf_gnt%0d_d", n), d_gnt, exp_d);
            chk($sformatf("conf_gnt%0d_if", n), if_gnt, !exp_d);
            owner_d = exp_d;
            n++;
         end
         @(posedge clk); #1;
      end
      chk("conf_grant_count", n, 8);
      if_req = 0; d_req = 0;
      @(posedge clk); @(posedge clk); #1;

      // ---- reset during ACCESS of a store ----
      d_req = 1; d_we = 1; d_addr = 32'hC; d_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("abort_d_gnt", d_gnt, 1);
      @(posedge clk); #1;
      d_req = 0; d_we = 0;
      @(negedge clk);
      chk("abort_mem_we_before", mem_we, 1);
      #2 rst_n = 1'b0;
      #1 chk("abort_mem_we_async", mem_we, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_no_rvalid", if_rvalid | d_rvalid, 0);
      end
      rst_n = 1'b1;
      m_loss = 0; m_last_d = 0;
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h0;
      @(negedge clk);
      chk("post_rst_if_gnt", if_gnt, 1);
      @(posedge clk); #1;
      if_req = 0;
      @(negedge clk);
      chk("post_rst_no_early", if_rvalid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_if_rvalid", if_rvalid, 1);
      chk("post_rst_if_rdata", if_rdata, 32'h0011_2223);
      chk("abort_word3_unchanged", mem[3], 32'h1000_0003);
      @(posedge clk); #1;

      // ---- randomized traffic against the transaction-level model ----
      for (int i = 0; i < 32; i++) mmem[i] = mem[i];
      if_pend = 0; d_pend = 0; d_w = 0; if_a = 0; d_a = 0; d_wd = 0;
      next_free = 0; we_cyc = -1; we_addr = 0; we_data = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1; if_a = 32'($urandom_range(0, 127));
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1; d_w = 1'($urandom_range(0, 1));
            d_a = 32'($urandom_range(0, 127)); d_wd = $urandom;
         end
         if_req = if_pend; if_addr = if_a;
         d_req = d_pend; d_we = d_w; d_addr = d_a; d_wdata = d_wd;
         @(negedge clk);
         exp_d = 0; owner_d = 0;
         if (cyc >= next_free && (if_pend || d_pend)) begin
            exp_d = model_grant(if_pend, d_pend);
            owner_d = 1;
            r.due = cyc + 2; r.is_d = exp_d; r.err = 0;
            if (exp_d) begin
               if (d_a[1:0] != 2'b00) begin
                  r.err = 1; r.data = 0;
               end else if (d_w) begin
                  mmem[d_a[6:2]] = d_wd; r.data = 0;
                  we_cyc = cyc + 1; we_addr = d_a; we_data = d_wd;
               end else r.data = mmem[d_a[6:2]];
               d_pend = 0;
            end else begin
               r.data = mmem[if_a[6:2]];
               if_pend = 0;
            end
            q.push_back(r);
            next_free = cyc + 3;
         end
         chk("rnd_d_gnt", d_gnt, owner_d & exp_d);
         chk("rnd_if_gnt", if_gnt, owner_d & !exp_d);
         if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            chk("rnd_if_rvalid", if_rvalid, !r.is_d);
            chk("rnd_d_rvalid", d_rvalid, r.is_d);
            chk("rnd_rdata", r.is_d ? d_rdata : if_rdata, r.data);
            chk("rnd_d_err", d_err, r.is_d & r.err);
         end else begin
            chk("rnd_rvalid_idle", if_rvalid | d_rvalid, 0);
         end
         chk("rnd_mem_we", mem_we, cyc == we_cyc);
         if (cyc == we_cyc) begin
            chk("rnd_mem_addr", mem_addr, we_addr);
            chk("rnd_mem_wdata", mem_wdata, we_data);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
